// File: rtl/divider_pkg.sv
// Width constants and FSM state type shared by the divider and its
// quotient reconstructor.
package divider_pkg;
    localparam int DW = 16;
    localparam int QW = DW + 1;
    localparam int RW = QW + DW;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/quotient_reconstructor.sv
// Rebuilds quotient*divisor (+ remainder) with an iterative shift-add
// multiplier, one quotient bit per clock, LSB first.
module quotient_reconstructor
    import divider_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    output logic          in_ready,
    input  logic          mode,
    input  logic [QW-1:0] quotient,
    input  logic [DW-1:0] divisor,
    input  logic [DW-1:0] remainder,
    output logic          valid_out,
    input  logic          out_ready,
    output logic [RW-1:0] result
);

    state_t        state_reg;
    state_t        state_next;
    logic [QW-1:0] q_shift_reg;
    logic [DW-1:0] divisor_reg;
    logic [RW-1:0] acc_reg;
    logic [RW-1:0] result_reg;
    logic [CW-1:0] step_reg;

    logic          last_step;
    logic [RW-1:0] addend;
    logic [RW-1:0] acc_sum;

    assign last_step = (step_reg == CW'(QW - 1));
    assign addend    = q_shift_reg[0] ? ({{(RW - DW){1'b0}}, divisor_reg} << step_reg) : '0;
    assign acc_sum   = acc_reg + addend;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; no early exit so latency is operand-independent
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_in)  state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_reg == IDLE);
        valid_out = (state_reg == DONE);
    end

    // Datapath; result_reg keeps its value after the handshake completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_shift_reg <= '0;
            divisor_reg <= '0;
            acc_reg     <= '0;
            result_reg  <= '0;
            step_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_in) begin
                        q_shift_reg <= quotient;
                        divisor_reg <= divisor;
                        acc_reg     <= mode ? {{(RW - DW){1'b0}}, remainder} : '0;
                        step_reg    <= '0;
                    end
                end
                RUN: begin
                    acc_reg     <= acc_sum;
                    q_shift_reg <= q_shift_reg >> 1;
                    step_reg    <= step_reg + 1'b1;
                    if (last_step) begin
                        result_reg <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_quotient_reconstructor.sv
// Randomized self-checking bench for quotient_reconstructor against an
// arithmetic reference (q*d + r).
module tb_quotient_reconstructor;
    import divider_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [QW-1:0] quotient = '0;
    logic [DW-1:0] divisor = '0;
    logic [DW-1:0] remainder = '0;
    logic          valid_out;
    logic          out_ready = 1'b1;
    logic [RW-1:0] result;

    int tests_run = 0;
    int tests_failed = 0;

    quotient_reconstructor dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .mode      (mode),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [63:0] q, input logic [63:0] d,
                                              input logic [63:0] r, input logic m);
        return q * d + (m ? r : 64'd0);
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        quotient  = QW'($urandom);
        divisor   = DW'($urandom);
        remainder = DW'($urandom);
        mode      = 1'($urandom);
    endtask

    // One full transaction: accept, latency, result, optional backpressure, release
    task automatic run_op(input logic [QW-1:0] q, input logic [DW-1:0] d,
                          input logic [DW-1:0] r, input logic m, input int stall);
        logic [63:0] exp_res;
        logic [RW-1:0] held;
        int n;
        exp_res = ref_model(64'(q), 64'(d), 64'(r), m);
        n = 0;
        while (!in_ready && n < 50) begin
            step_clk();
            n++;
        end
        check_val("in_ready_before_accept", 64'(in_ready), 64'd1);
        quotient  = q;
        divisor   = d;
        remainder = r;
        mode      = m;
        valid_in  = 1'b1;
        out_ready = (stall == 0);
        step_clk();
        valid_in = 1'b0;
        scramble_inputs();
        check_val("in_ready_after_accept", 64'(in_ready), 64'd0);
        n = 0;
        while (!valid_out && n < 40) begin
            step_clk();
            n++;
        end
        check_val("latency", 64'(n), 64'd17);
        check_val("result", 64'(result), exp_res);
        held = result;
        for (int i = 0; i < stall; i++) begin
            valid_in = 1'b1;
            scramble_inputs();
            step_clk();
            check_val("hold_valid_out", 64'(valid_out), 64'd1);
            check_val("hold_result", 64'(result), 64'(held));
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        valid_in  = 1'b0;
        out_ready = 1'b1;
        step_clk();
        check_val("release_valid_out", 64'(valid_out), 64'd0);
        check_val("release_in_ready", 64'(in_ready), 64'd1);
        check_val("release_result_kept", 64'(result), 64'(held));
        $display("[TB] op q=0x%0h d=0x%0h r=0x%0h mode=%0d stall=%0d -> result=0x%0h (exp 0x%0h)",
                 q, d, r, m, stall, held, exp_res);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_valid_out", 64'(valid_out), 64'd0);
        check_val("reset_in_ready", 64'(in_ready), 64'd1);
        check_val("reset_result", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step_clk();

        run_op(17'd5, 16'd7, 16'd3, 1'b0, 0);
        run_op(17'd5, 16'd7, 16'd3, 1'b1, 0);
        run_op(17'd142, 16'd7, 16'd6, 1'b1, 0);
        run_op(17'h1FFFF, 16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_op(17'h1FFFF, 16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_op(17'd77, 16'd1234, 16'd55, 1'b1, 5);
        run_op(17'd0, 16'hFFFF, 16'd9, 1'b1, 0);
        run_op(17'h1FFFF, 16'd0, 16'd0, 1'b0, 0);

        // Reset asserted partway through RUN discards the operation
        quotient  = 17'h1234;
        divisor   = 16'h55;
        remainder = 16'd0;
        mode      = 1'b0;
        valid_in  = 1'b1;
        step_clk();
        valid_in = 1'b0;
        repeat (8) step_clk();
        #2;
        reset = 1'b0;
        #1;
        check_val("midrun_reset_valid_out", 64'(valid_out), 64'd0);
        check_val("midrun_reset_result", 64'(result), 64'd0);
        check_val("midrun_reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        step_clk();
        run_op(17'd3, 16'd4, 16'd0, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            run_op(QW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
